vga_display_driver: RTL
=======================

VGA_DISPLAY_DRIVER -- requirements
Module: vga_display_driver

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16, horizontal front porch in clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 96, hsync pulse width in clocks.
REQ-004 The block SHALL have parameter H_BACK, default 48, horizontal back porch in clocks.
REQ-005 The block SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 The block SHALL have parameters V_FRONT, V_SYNC and V_BACK, defaults 10, 2 and 33, measured in lines.
REQ-007 The block SHALL have parameter RGB_LATENCY, default 2, range 0..4: clocks from a pixelX/pixelY value until its RGB_in arrives.
REQ-008 The block SHALL have a single clock and an asynchronous active-low reset, with ports clk (in, 1) and resetN (in, 1).
REQ-009 The block SHALL have port RGB_in, in, 8 bits: pixel colour in 3-3-2 format, R=[7:5], G=[4:2], B=[1:0].
REQ-010 The block SHALL have ports pixelX and pixelY, out, 11 bits each: the current horizontal and vertical counters.
REQ-011 The block SHALL have port startOfFrame, out, 1 bit: one-clock frame-update pulse.
REQ-012 The block SHALL have ports VGA_HS and VGA_VS, out, 1 bit each: active-low sync outputs aligned to the pixel data.
REQ-013 The block SHALL have port VGA_BLANK_N, out, 1 bit: low outside the visible area, aligned to the pixel data.
REQ-014 The block SHALL have ports VGA_R, VGA_G and VGA_B, out, 4 bits each: expanded colour.
REQ-015 The block SHALL have port frame_count, out, 16 bits: number of completed frames.

Function
REQ-016 The block SHALL advance one pixel per clk, with H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800) and V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
REQ-017 hcount SHALL increment every clock and wrap from H_TOTAL-1 to 0.
REQ-018 vcount SHALL increment only on the hcount wrap clock and wrap from V_TOTAL-1 to 0 on that same clock.
REQ-019 pixelX and pixelY SHALL equal hcount and vcount, including blanking values, and SHALL be registered.
REQ-020 startOfFrame SHALL be high for exactly one clock, when hcount==0 and vcount==V_VISIBLE, i.e. once per frame at the start of vertical blanking.
REQ-021 The internal raw hsync SHALL be low while hcount is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. [656,751].
REQ-022 The internal raw vsync SHALL be low while vcount is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. [490,491], for whole lines.
REQ-023 The internal raw visible flag SHALL be high when hcount<H_VISIBLE and vcount<V_VISIBLE.
REQ-024 Raw hsync, vsync and visible SHALL pass through a RGB_LATENCY-stage shift register; RGB_LATENCY=0 SHALL mean direct use.
REQ-025 VGA_HS, VGA_VS and VGA_BLANK_N SHALL be registered once more from the shift-register outputs, giving total latency RGB_LATENCY+1 relative to pixelX/pixelY.
REQ-026 RGB_in SHALL be registered once, on the same final stage as the syncs.
REQ-027 When the delayed visible flag is high, colour expansion SHALL be VGA_R={R,R[2]}, VGA_G={G,G[2]} and VGA_B={B,B}.
REQ-028 When the delayed visible flag is low, VGA_R, VGA_G and VGA_B SHALL be 0 regardless of RGB_in.
REQ-029 frame_count SHALL increment on the clock where hcount and vcount both wrap to 0, and SHALL wrap from 0xFFFF to 0.
REQ-030 The block SHALL have no dependency on RGB_in for timing; an X or constant RGB_in SHALL never affect the syncs or counters.

Reset
REQ-031 While resetN is low, asynchronously: hcount, vcount, pixelX, pixelY and frame_count SHALL be 0; startOfFrame SHALL be 0; VGA_HS and VGA_VS SHALL be 1; VGA_BLANK_N SHALL be 0; colour outputs SHALL be 0; all delay stages SHALL be cleared to the inactive level (sync 1, visible 0).
REQ-032 On the first clock after resetN rises, hcount SHALL become 1; the first visible pixel (0,0) SHALL be presented while in reset and at the wrap.
REQ-033 Reset asserted mid-frame SHALL restart timing at (0,0), with no partial sync pulse emitted after release.

Verification
REQ-034 Free-run 2 frames from reset -> VGA_HS period 800 clocks with low width 96; VGA_VS period 420000 clocks with low width 1600 clocks; startOfFrame pulses exactly 420000 clocks apart.
REQ-035 Sample at pixelX=639,pixelY=479 then 640 -> VGA_BLANK_N is 1 and then 0, each RGB_LATENCY+1 clocks later.
REQ-036 RGB_in=8'hE0 driven at the correct latency in the visible area -> VGA_R=4'hF, VGA_G=0, VGA_B=0; RGB_in=8'h03 -> VGA_B=4'hF; blanking region with RGB_in=8'hFF -> all colour 0.
REQ-037 Pulse resetN low at pixelY=490, pixelX=700 -> immediate HS=VS=1, BLANK_N=0, counters 0; after release, next vsync starts 490 lines later.
REQ-038 Force frame_count to 0xFFFF by running 65536 frames, or with a reduced-parameter build (H_VISIBLE=8, V_VISIBLE=4, porches 1) -> wraps to 0; startOfFrame still one clock per frame.
REQ-039 RGB_LATENCY=0 build -> VGA_HS falls exactly 1 clock after pixelX==656.

Source files
------------

// File: rtl/vga_display_driver.sv
// vga_display_driver: VGA timing generator with pixel counters, a configurable RGB
// return-latency pipeline, 3-3-2 colour expansion and a frame counter.
module vga_display_driver #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int RGB_LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  RGB_in,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic [15:0] frame_count
);
  localparam logic [10:0] H_LAST = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] V_LAST = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  logic [10:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic [15:0] frame_q, frame_d;
  logic        sof_q, sof_d, h_wrap;
  logic        hs_q, vs_q, blank_n_q;
  logic [3:0]  r_q, g_q, b_q, r_d, g_d, b_d;
  // {visible, vsync_n, hsync_n}; reset level of every stage is 3'b011
  logic [2:0]  raw, dly;
  always_comb begin
    h_wrap   = hcount_q == H_LAST;
    hcount_d = h_wrap ? '0 : hcount_q + 11'd1;
    vcount_d = !h_wrap ? vcount_q : (vcount_q == V_LAST ? '0 : vcount_q + 11'd1);
    frame_d  = (h_wrap && vcount_q == V_LAST) ? frame_q + 16'd1 : frame_q;
    sof_d    = hcount_d == '0 && vcount_d == V_VIS;
    raw      = {hcount_q < H_VIS && vcount_q < V_VIS,
                !(vcount_q >= VS_BEG && vcount_q < VS_END),
                !(hcount_q >= HS_BEG && hcount_q < HS_END)};
    r_d      = dly[2] ? {RGB_in[7:5], RGB_in[7]}   : '0;
    g_d      = dly[2] ? {RGB_in[4:2], RGB_in[4]}   : '0;
    b_d      = dly[2] ? {RGB_in[1:0], RGB_in[1:0]} : '0;
  end
  // Delay the raw timing so it meets the RGB value fetched for the same pixel
  generate
    if (RGB_LATENCY == 0) begin : g_direct
      assign dly = raw;
    end else begin : g_pipe
      logic [2:0] sr_q [RGB_LATENCY];
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          for (int i = 0; i < RGB_LATENCY; i++) sr_q[i] <= 3'b011;
        end else begin
          sr_q[0] <= raw;
          for (int i = 1; i < RGB_LATENCY; i++) sr_q[i] <= sr_q[i-1];
        end
      end
      assign dly = sr_q[RGB_LATENCY-1];
    end
  endgenerate
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hcount_q  <= '0;
      vcount_q  <= '0;
      frame_q   <= '0;
      sof_q     <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      frame_q   <= frame_d;
      sof_q     <= sof_d;
      hs_q      <= dly[0];
      vs_q      <= dly[1];
      blank_n_q <= dly[2];
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end
  assign pixelX       = hcount_q;
  assign pixelY       = vcount_q;
  assign startOfFrame = sof_q;
  assign frame_count  = frame_q;
  assign VGA_HS       = hs_q;
  assign VGA_VS       = vs_q;
  assign VGA_BLANK_N  = blank_n_q;
  assign VGA_R        = r_q;
  assign VGA_G        = g_q;
  assign VGA_B        = b_q;
endmodule
